// File: rtl/c_ext_fetch_state.sv
// c_ext_fetch_state: IF-stage C-extension state tracker feeding the instruction aligner.
// Tracks the buffered fetch word, the compressed-at-low-half flag, a three-state
// spanning FSM (IDLE -> WAIT -> SPAN) for 32-bit instructions that straddle a word
// boundary, and stall bookkeeping. Every output comes straight from a register.
// Ports:
//   i_clk, i_rst                         clock, synchronous active-high reset
//   i_stall, i_flush                     hold / clear (flush wins over stall)
//   i_pc_reg                             registered PC, only bit 1 matters
//   i_instr, i_effective_instr           raw memory word, aligner-selected word
//   i_is_compressed, i_sel_nop           aligner classification this cycle
//   i_spanning_to_halfword               spanning completion lands on halfword PC
//   o_instr_buffer                       buffered word
//   o_prev_was_compressed_at_lo(_saved)  live flag and copy captured on stall entry
//   o_stall_registered                   i_stall delayed one cycle
//   o_spanning_wait_for_fetch            FSM in WAIT
//   o_spanning_in_progress               FSM in SPAN
//   o_spanning_buffer, _second_half      halves of the spanning instruction
//   o_spanning_to_halfword_registered    i_spanning_to_halfword delayed one advance
//   o_use_buffer_after_spanning          one-cycle pulse after the holdoff cycle
// Optional: define FROST_SPAN_PERF_EN to add o_span_count and o_comp_count.
module c_ext_fetch_state #(
    parameter int XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_stall,
    input  logic            i_flush,
    input  logic [XLEN-1:0] i_pc_reg,
    input  logic [31:0]     i_instr,
    input  logic [31:0]     i_effective_instr,
    input  logic            i_is_compressed,
    input  logic            i_sel_nop,
    input  logic            i_spanning_to_halfword,
    output logic [31:0]     o_instr_buffer,
    output logic            o_prev_was_compressed_at_lo,
    output logic            o_prev_was_compressed_at_lo_saved,
    output logic            o_stall_registered,
    output logic            o_spanning_wait_for_fetch,
    output logic            o_spanning_in_progress,
    output logic [15:0]     o_spanning_buffer,
    output logic [15:0]     o_spanning_second_half,
    output logic            o_spanning_to_halfword_registered,
    output logic            o_use_buffer_after_spanning
`ifdef FROST_SPAN_PERF_EN
    ,
    output logic [31:0]     o_span_count,
    output logic [31:0]     o_comp_count
`endif
);
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_SPAN} state_t;
    state_t      r_state, w_state;
    logic [31:0] r_instr_buffer, w_instr_buffer;
    logic        r_prev, w_prev;
    logic        r_saved, w_saved;
    logic        r_stall_reg;
    logic [15:0] r_span_buf, w_span_buf;
    logic [15:0] r_span_second, w_span_second;
    logic        r_hw_reg, w_hw_reg;
    logic        r_use_buf, w_use_buf;
    logic        w_adv;
    logic        w_unused;
    assign w_adv    = !i_stall && !i_flush;
    assign w_unused = ^{i_pc_reg[XLEN-1:2], i_pc_reg[0]};
    always_comb begin
        w_state        = r_state;
        w_instr_buffer = r_instr_buffer;
        w_prev         = r_prev;
        w_saved        = r_saved;
        w_span_buf     = r_span_buf;
        w_span_second  = r_span_second;
        w_hw_reg       = r_hw_reg;
        w_use_buf      = r_use_buf;
        if (i_flush) begin
            w_state        = S_IDLE;
            w_instr_buffer = '0;
            w_prev         = 1'b0;
            w_saved        = 1'b0;
            w_span_buf     = '0;
            w_span_second  = '0;
            w_hw_reg       = 1'b0;
            w_use_buf      = 1'b0;
        end else if (i_stall) begin
            w_saved = r_stall_reg ? r_saved : r_prev;
        end else begin
            w_hw_reg  = i_spanning_to_halfword;
            // Pulse once the holdoff cycle has passed, never two cycles running.
            w_use_buf = r_hw_reg && !r_use_buf;
            case (r_state)
                S_IDLE: begin
                    w_prev = i_is_compressed && !i_pc_reg[1] && !i_sel_nop;
                    if (!i_pc_reg[1]) w_instr_buffer = i_effective_instr;
                    if (i_pc_reg[1] && !i_is_compressed) begin
                        w_span_buf = i_effective_instr[31:16];
                        w_state    = S_WAIT;
                    end
                end
                S_WAIT: begin
                    w_span_second  = i_instr[15:0];
                    w_instr_buffer = i_instr;
                    w_state        = S_SPAN;
                end
                default: w_state = S_IDLE;
            endcase
        end
    end
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state        <= S_IDLE;
            r_instr_buffer <= '0;
            r_prev         <= 1'b0;
            r_saved        <= 1'b0;
            r_stall_reg    <= 1'b0;
            r_span_buf     <= '0;
            r_span_second  <= '0;
            r_hw_reg       <= 1'b0;
            r_use_buf      <= 1'b0;
        end else begin
            r_state        <= w_state;
            r_instr_buffer <= w_instr_buffer;
            r_prev         <= w_prev;
            r_saved        <= w_saved;
            r_stall_reg    <= i_stall;
            r_span_buf     <= w_span_buf;
            r_span_second  <= w_span_second;
            r_hw_reg       <= w_hw_reg;
            r_use_buf      <= w_use_buf;
        end
    end
    assign o_instr_buffer                    = r_instr_buffer;
    assign o_prev_was_compressed_at_lo       = r_prev;
    assign o_prev_was_compressed_at_lo_saved = r_saved;
    assign o_stall_registered                = r_stall_reg;
    assign o_spanning_wait_for_fetch         = r_state == S_WAIT;
    assign o_spanning_in_progress            = r_state == S_SPAN;
    assign o_spanning_buffer                 = r_span_buf;
    assign o_spanning_second_half            = r_span_second;
    assign o_spanning_to_halfword_registered = r_hw_reg;
    assign o_use_buffer_after_spanning       = r_use_buf;
`ifdef FROST_SPAN_PERF_EN
    logic [31:0] r_span_count, r_comp_count;
    // Counters survive flush so they measure the whole run, not one redirect window.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_span_count <= '0;
            r_comp_count <= '0;
        end else if (w_adv) begin
            r_span_count <= r_span_count + 32'(r_state == S_SPAN);
            r_comp_count <= r_comp_count + 32'(i_is_compressed && !i_sel_nop);
        end
    end
    assign o_span_count = r_span_count;
    assign o_comp_count = r_comp_count;
`endif
endmodule

// File: tb/tb_c_ext_fetch_state.sv
// tb_c_ext_fetch_state: scoreboard bench for c_ext_fetch_state with a behavioural model.
module tb_c_ext_fetch_state;
    logic        clk = 0;
    logic        i_rst = 1, i_stall = 0, i_flush = 0;
    logic [31:0] i_pc_reg = 0, i_instr = 0, i_effective_instr = 0;
    logic        i_is_compressed = 0, i_sel_nop = 0, i_spanning_to_halfword = 0;
    logic [31:0] o_instr_buffer;
    logic        o_prev, o_saved, o_stall_reg, o_wait, o_inprog, o_hw_reg, o_use_buf;
    logic [15:0] o_span_buf, o_span_second;
`ifdef FROST_SPAN_PERF_EN
    logic [31:0] o_span_count, o_comp_count;
`endif
    always #5 clk = ~clk;

    c_ext_fetch_state #(.XLEN(32)) dut (
        .i_clk(clk), .i_rst(i_rst), .i_stall(i_stall), .i_flush(i_flush),
        .i_pc_reg(i_pc_reg), .i_instr(i_instr), .i_effective_instr(i_effective_instr),
        .i_is_compressed(i_is_compressed), .i_sel_nop(i_sel_nop),
        .i_spanning_to_halfword(i_spanning_to_halfword),
        .o_instr_buffer(o_instr_buffer), .o_prev_was_compressed_at_lo(o_prev),
        .o_prev_was_compressed_at_lo_saved(o_saved), .o_stall_registered(o_stall_reg),
        .o_spanning_wait_for_fetch(o_wait), .o_spanning_in_progress(o_inprog),
        .o_spanning_buffer(o_span_buf), .o_spanning_second_half(o_span_second),
        .o_spanning_to_halfword_registered(o_hw_reg),
        .o_use_buffer_after_spanning(o_use_buf)
`ifdef FROST_SPAN_PERF_EN
        , .o_span_count(o_span_count), .o_comp_count(o_comp_count)
`endif
    );

    typedef struct packed {
        logic [31:0] buffer;
        logic        prev, saved, stall_reg;
        logic [1:0]  phase;  // 0 no span pending, 1 waiting for next word, 2 completing
        logic [15:0] first_half, second_half;
        logic        hw, use_buf;
        logic [31:0] spans, comps;
    } exp_t;

    exp_t m;
    exp_t sb[$];
    int   checks = 0, failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // One clock of stimulus: drive inputs and predict the registers after the next edge.
    task automatic step(input logic rst, stall, flush, input logic [31:0] pc, instr, eff,
                        input logic comp, nop, hw);
        exp_t n;
        @(negedge clk);
        i_rst = rst; i_stall = stall; i_flush = flush; i_pc_reg = pc; i_instr = instr;
        i_effective_instr = eff; i_is_compressed = comp; i_sel_nop = nop;
        i_spanning_to_halfword = hw;
        n = m;
        if (rst) n = '0;
        else if (flush) begin
            n = '0;
            n.stall_reg = stall;
            n.spans = m.spans;
            n.comps = m.comps;
        end else if (stall) begin
            if (!m.stall_reg) n.saved = m.prev;
            n.stall_reg = 1;
        end else begin
            n.stall_reg = 0;
            n.hw = hw;
            n.use_buf = m.hw && !m.use_buf;
            if (comp && !nop) n.comps = m.comps + 1;
            if (m.phase == 0) begin
                n.prev = comp && !pc[1] && !nop;
                if (!pc[1]) n.buffer = eff;
                else if (!comp) begin
                    n.first_half = eff[31:16];
                    n.phase = 1;
                end
            end else if (m.phase == 1) begin
                n.second_half = instr[15:0];
                n.buffer = instr;
                n.phase = 2;
            end else begin
                n.phase = 0;
                n.spans = m.spans + 1;
            end
        end
        m = n;
        sb.push_back(n);
    endtask

    task automatic adv(input logic [31:0] pc, instr, eff, input logic comp);
        step(0, 0, 0, pc, instr, eff, comp, 0, 0);
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("instr_buffer", o_instr_buffer, e.buffer);
                chk("prev_flag", 32'(o_prev), 32'(e.prev));
                chk("saved_flag", 32'(o_saved), 32'(e.saved));
                chk("stall_reg", 32'(o_stall_reg), 32'(e.stall_reg));
                chk("wait", 32'(o_wait), 32'(e.phase == 1));
                chk("in_progress", 32'(o_inprog), 32'(e.phase == 2));
                chk("span_buf", 32'(o_span_buf), 32'(e.first_half));
                chk("span_second", 32'(o_span_second), 32'(e.second_half));
                chk("hw_reg", 32'(o_hw_reg), 32'(e.hw));
                chk("use_buf", 32'(o_use_buf), 32'(e.use_buf));
`ifdef FROST_SPAN_PERF_EN
                chk("span_count", o_span_count, e.spans);
                chk("comp_count", o_comp_count, e.comps);
`endif
            end
        end
    end

    initial begin
        m = '0;
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        settle();
        chk("reset_buffer", o_instr_buffer, 0);
        chk("reset_wait", 32'(o_wait), 0);
        // Compressed pair at 0x100 / 0x102
        adv(32'h100, 32'h4501_4505, 32'h4501_4505, 1);
        settle();
        chk("pair_prev_lo", 32'(o_prev), 1);
        chk("pair_buffer", o_instr_buffer, 32'h4501_4505);
        adv(32'h102, 32'h4501_4505, 32'h4501_4505, 1);
        settle();
        chk("pair_prev_hi", 32'(o_prev), 0);
        // Spanning sequence
        adv(32'h102, 32'h1234_0001, 32'h1234_0001, 0);
        settle();
        chk("span_wait", 32'(o_wait), 1);
        chk("span_first", 32'(o_span_buf), 32'h1234);
        adv(32'h104, 32'hBEEF_0067, 32'hBEEF_0067, 0);
        settle();
        chk("span_second", 32'(o_span_second), 32'h0067);
        chk("span_inprog", 32'(o_inprog), 1);
        chk("span_buffer", o_instr_buffer, 32'hBEEF_0067);
        step(0, 0, 0, 32'h106, 0, 0, 0, 0, 1);
        settle();
        chk("span_idle", 32'(o_inprog | o_wait), 0);
        // Stall three cycles while in SPAN
        adv(32'h102, 32'hAAAA_0003, 32'h5555_0003, 0);
        adv(32'h104, 32'h0000_0013, 32'h0000_0013, 0);
        for (int k = 0; k < 3; k++) begin
            step(0, 1, 0, 32'h106, $urandom, $urandom, 1, 0, 0);
            settle();
            chk("stall_inprog", 32'(o_inprog), 1);
            chk("stall_reg_high", 32'(o_stall_reg), 1);
        end
        adv(32'h106, 0, 0, 0);
        settle();
        chk("stall_release_idle", 32'(o_inprog), 0);
        // Reset mid-WAIT
        adv(32'h102, 32'h1111_2222, 32'h3333_4444, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        settle();
        chk("rst_midwait", 32'(o_wait), 0);
        chk("rst_spanbuf", 32'(o_span_buf), 0);
        // Flush with simultaneous stall while in WAIT
        adv(32'h102, 32'h1111_2222, 32'h3333_4444, 0);
        step(0, 1, 1, 32'h104, 32'h5, 32'h5, 0, 0, 0);
        settle();
        chk("flush_wait", 32'(o_wait), 0);
        chk("flush_spanbuf", 32'(o_span_buf), 0);
        chk("flush_stall_reg", 32'(o_stall_reg), 1);
`ifdef FROST_SPAN_PERF_EN
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 2; k++) begin
            adv(32'h102, 32'hDEAD_0001, 32'hDEAD_0001, 0);
            adv(32'h104, 32'h0000_BEEF, 32'h0000_BEEF, 0);
            adv(32'h108, 32'h0000_0013, 32'h0000_0013, 0);
        end
        for (int k = 0; k < 5; k++) adv(32'h100, 32'h4501_4505, 32'h4501_4505, 1);
        settle();
        chk("perf_spans", o_span_count, 2);
        chk("perf_comps", o_comp_count, 5);
        step(0, 0, 1, 0, 0, 0, 0, 0, 0);
        settle();
        chk("perf_spans_flush", o_span_count, 2);
        chk("perf_comps_flush", o_comp_count, 5);
`endif
        // Randomized traffic
        for (int k = 0; k < 3000; k++) begin
            step($urandom_range(63) == 0, $urandom_range(3) == 0, $urandom_range(15) == 0,
                 $urandom, $urandom, $urandom, 1'($urandom), $urandom_range(7) == 0,
                 (m.phase == 2) && 1'($urandom));
        end
        for (int k = 0; k < 10 && sb.size() != 0; k++) @(posedge clk);
        #3;
        chk("scoreboard_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
